// File: rtl/apb_reg_slave.sv
// APB3 completer exposing DEPTH word-indexed DATA_WIDTH-bit read/write registers.
// Define APB_WAIT_STATE_EN to insert exactly one wait state into every transfer.
module apb_reg_slave #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef APB_WAIT_STATE_EN
    localparam bit WaitEn = 1'b1;
`else
    localparam bit WaitEn = 1'b0;
`endif

    // state_q records the bus phase of the cycle that just ended
    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StWait
    } state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] prdata_q;
    logic                  in_range;
    logic                  setup_phase;
    logic                  access_ok;
    logic [IdxW-1:0]       idx;

    assign in_range    = 64'(paddr) < 64'(DEPTH);
    assign idx         = paddr[IdxW-1:0];
    assign setup_phase = psel && !penable;

    // Completion needs a SETUP (and, with wait states, the WAIT cycle) right before it;
    // a bare penable with no preceding SETUP never completes.
    always_comb begin
        if (WaitEn) begin
            access_ok = psel && penable && (state_q == StWait);
        end else begin
            access_ok = psel && penable && (state_q == StSetup);
        end
    end

    assign pready  = access_ok && !rst;
    assign pslverr = pready && !in_range;
    assign prdata  = prdata_q;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            prdata_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (!psel) begin
                state_q <= StIdle;
            end else if (!penable) begin
                state_q <= StSetup;
            end else begin
                unique case (state_q)
                    StSetup: state_q <= WaitEn ? StWait : StAccess;
                    StWait:  state_q <= StAccess;
                    default: state_q <= StIdle;
                endcase
            end

            // Read data is loaded entering ACCESS so it is stable when pready rises.
            if (setup_phase && !pwrite) begin
                prdata_q <= in_range ? mem_q[idx] : '0;
            end

            if (access_ok && pwrite && in_range) begin
                mem_q[idx] <= pwdata;
            end
        end
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench for apb_reg_slave: stimulus pushes expected responses from a
// register-array model, a negedge monitor pops and compares on every completion.
module tb_apb_reg_slave;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 64;

`ifdef APB_WAIT_STATE_EN
    localparam int ExpWaits = 1;
`else
    localparam int ExpWaits = 0;
`endif

    logic          pclk    = 1'b0;
    logic          rst     = 1'b1;
    logic          psel    = 1'b0;
    logic          penable = 1'b0;
    logic          pwrite  = 1'b0;
    logic [AW-1:0] paddr   = '0;
    logic [DW-1:0] pwdata  = '0;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    apb_reg_slave #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .pclk   (pclk),
        .rst    (rst),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .paddr  (paddr),
        .pwdata (pwdata),
        .prdata (prdata),
        .pready (pready),
        .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        bit            rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            err;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [DW-1:0] model[DEPTH];
    int            checks   = 0;
    int            failures = 0;

    bit            r_wr;
    int            r_addr;
    logic [DW-1:0] r_data;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge pclk) begin
        if (!rst && psel && penable && pready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_completion: got pready=1 at addr %0d, expected none", paddr);
            end else begin
                mon_e = sb.pop_front();
                check("completion_addr", {24'b0, paddr}, {24'b0, mon_e.addr});
                check("pslverr", {31'b0, pslverr}, {31'b0, mon_e.err});
                if (mon_e.rd) begin
                    check("prdata", prdata, mon_e.data);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the completing edge with psel still high.
    task automatic xfer(input bit wr, input int addr, input logic [DW-1:0] data);
        exp_t e;
        int   waits;
        bit   done;
        e.rd   = !wr;
        e.addr = addr[AW-1:0];
        e.err  = (addr >= DEPTH);
        e.data = '0;
        if (!e.err) begin
            if (wr) model[addr] = data;
            else    e.data = model[addr];
        end
        sb.push_back(e);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr[AW-1:0];
        pwdata  = data;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        waits   = 0;
        done    = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge pclk);
            if (pready) done = 1'b1;
            else        waits++;
            @(posedge pclk);
            #1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL xfer_timeout: got no pready for addr %0d, expected completion", addr);
        end else begin
            check("wait_states", waits, ExpWaits);
        end
    endtask

    task automatic idle(input int n);
        psel    = 1'b0;
        penable = 1'b0;
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, expected end of test");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        rst = 1'b1;
        repeat (5) begin
            @(posedge pclk);
            #1;
        end
        check("reset_pready", {31'b0, pready}, 32'd0);
        check("reset_prdata", prdata, 32'd0);
        check("reset_pslverr", {31'b0, pslverr}, 32'd0);
        rst = 1'b0;
        idle(2);

        xfer(0, 2, '0);
        xfer(0, 4, '0);
        xfer(0, 8, '0);
        idle(100);
        xfer(1, 2, 32'd16);
        idle(5);
        xfer(0, 2, '0);
        xfer(1, 4, 32'd32);
        xfer(0, 4, '0);
        xfer(1, 8, 32'd16);
        xfer(0, 8, '0);
        xfer(0, 2, '0);
        idle(1);

        xfer(1, 5, 32'hDEADBEEF);
        xfer(0, 5, '0);
        xfer(1, 70, 32'h55);
        xfer(0, 70, '0);
        xfer(0, 63, '0);
        xfer(1, 64, 32'h1234);
        idle(2);

        // penable without SETUP must be ignored
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 8'd6;
        pwdata  = 32'hAA;
        repeat (2) begin
            @(negedge pclk);
            check("pready_no_setup", {31'b0, pready}, 32'd0);
            @(posedge pclk);
            #1;
        end
        idle(1);
        xfer(0, 6, '0);

        repeat (300) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_addr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(64, 255))
                   : ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7))
                   : int'($urandom_range(0, 63));
            r_data = $urandom;
            xfer(r_wr, r_addr, r_data);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(1);

        // reset mid-ACCESS: the write must be dropped and all registers cleared
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'd3;
        pwdata  = 32'h99;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("pready_on_reset", {31'b0, pready}, 32'd0);
        check("prdata_on_reset", prdata, 32'd0);
        @(posedge pclk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        repeat (2) begin
            @(posedge pclk);
            #1;
        end
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        idle(1);
        xfer(0, 3, '0);
        xfer(0, 5, '0);
        xfer(0, 2, '0);
        idle(3);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
